adc_capture_ctrl: RTL and testbench

- FPGA-side SPI/conversion master for the team's 32-bit multi-lane SAR ADC (the device our adc_model emulates).
- Sequences cnv, waits for busy to fall, clocks out one 32-bit sample over 1, 2 or 4 SDO lanes and presents it on a valid/ready stream.
- Also performs the three-transaction register-access sequence that sets the lane mode: enter, write mode register, exit.

---
 rtl/adc_pkg.sv | 49 ++++
 rtl/adc_capture_ctrl_spi_engine.sv | 78 +++++++
 rtl/adc_capture_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: lane modes, register command words, FSM state type and
// helpers shared by the ADC capture controller and its SPI engine.
package adc_pkg;

    localparam logic [1:0] LaneModeOne  = 2'b00;
    localparam logic [1:0] LaneModeTwo  = 2'b01;
    localparam logic [1:0] LaneModeFour = 2'b10;

    localparam logic [14:0] ExitReg = 15'h0014;
    localparam logic [14:0] ModeReg = 15'h0020;

    localparam logic [23:0] CmdEnter = 24'hA00000;
    localparam logic [23:0] CmdExit  = {1'b0, ExitReg, 8'h01};

    localparam logic [5:0] CfgPulses = 6'd24;

    typedef enum logic [2:0] {
        IDLE,
        CNV_PULSE,
        WAIT_BUSY,
        RD_XFER,
        OUT,
        CFG_XFER,
        CSN_WAIT
    } state_t;

    function automatic logic [23:0] mode_cmd(input logic [1:0] md);
        return {1'b0, ModeReg, md, 6'b0};
    endfunction

    // Register-access sequence: 0 enter, 1 mode write, 2 exit.
    function automatic logic [23:0] cfg_cmd(input logic [1:0] idx,
                                            input logic [1:0] md);
        case (idx)
            2'd0:    return CmdEnter;
            2'd1:    return mode_cmd(md);
            default: return CmdExit;
        endcase
    endfunction

    function automatic logic [5:0] sck_pulses(input logic [1:0] md);
        case (md)
            LaneModeTwo:  return 6'd16;
            LaneModeFour: return 6'd8;
            default:      return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_spi_engine.sv
// adc_spi_engine: csn/sck timing for one SPI transaction of a given pulse
// count; shifts sdi out MSB first and strobes sample as sck rises.
module adc_spi_engine #(
    parameter int SCK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [5:0]  pulses,
    input  logic [23:0] tx_word,
    output logic        sck,
    output logic        csn,
    output logic        sdi,
    output logic        sample,
    output logic        done
);

    logic        active;
    logic        tail;
    logic [15:0] div_cnt;
    logic [5:0]  pulse_cnt;
    logic [5:0]  pulse_num;
    logic [23:0] shreg;
    logic        phase_end;

    assign phase_end = active && !tail && (div_cnt == 16'(SCK_DIV - 1));
    assign sample    = phase_end && !sck;

    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            tail      <= 1'b0;
            div_cnt   <= '0;
            pulse_cnt <= '0;
            pulse_num <= '0;
            shreg     <= '0;
            sck       <= 1'b0;
            csn       <= 1'b1;
            sdi       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go && !active) begin
                active    <= 1'b1;
                tail      <= 1'b0;
                csn       <= 1'b0;
                sck       <= 1'b0;
                div_cnt   <= '0;
                pulse_cnt <= '0;
                pulse_num <= pulses;
                sdi       <= tx_word[23];
                shreg     <= {tx_word[22:0], 1'b0};
            end else if (tail) begin
                // sck already low for a cycle; close the frame
                active <= 1'b0;
                tail   <= 1'b0;
                csn    <= 1'b1;
                sdi    <= 1'b0;
                done   <= 1'b1;
            end else if (phase_end) begin
                div_cnt <= '0;
                sck     <= !sck;
                if (sck) begin
                    pulse_cnt <= pulse_cnt + 6'd1;
                    if (pulse_cnt == pulse_num - 6'd1) begin
                        tail <= 1'b1;
                    end else begin
                        sdi   <= shreg[23];
                        shreg <= {shreg[22:0], 1'b0};
                    end
                end
            end else if (active) begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: conversion/readback and lane-mode config master for the
// multi-lane SAR ADC. Define ADC_BUSY_TIMEOUT_EN to enable the busy timeout.
module adc_capture_ctrl
    import adc_pkg::*;
#(
    parameter int SCK_DIV      = 2,
    parameter int CNV_HIGH     = 4,
    parameter int CSN_GAP      = 4,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cfg_req,
    input  logic [1:0]  cfg_lane_md,
    output logic        idle,
    output logic [1:0]  lane_md,
    output logic        cnv,
    input  logic        busy,
    output logic        sck,
    output logic        csn,
    output logic        sdi,
    input  logic [3:0]  sdo,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        timeout
);

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic        cnt_clr;
    logic        busy_m;
    logic        busy_s;
    logic        seen_high;
    logic [31:0] sr;
    logic [31:0] sr_shift;
    logic [31:0] m_data_r;
    logic [1:0]  lane_md_r;
    logic [1:0]  md_lat;
    logic [1:0]  cfg_idx;
    logic        cfg_active;
    logic        go;
    logic [5:0]  pulses;
    logic [23:0] tx_word;
    logic        sample;
    logic        done;
    logic        cap;
    logic        load_cfg;
    logic        cfg_step;
    logic        cfg_end;
`ifdef ADC_BUSY_TIMEOUT_EN
    logic        to_set;
    logic        timeout_r;
`endif

    adc_spi_engine #(
        .SCK_DIV(SCK_DIV)
    ) u_spi (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .pulses  (pulses),
        .tx_word (tx_word),
        .sck     (sck),
        .csn     (csn),
        .sdi     (sdi),
        .sample  (sample),
        .done    (done)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        go       = 1'b0;
        tx_word  = '0;
        pulses   = sck_pulses(lane_md_r);
        cnt_clr  = 1'b0;
        cap      = 1'b0;
        load_cfg = 1'b0;
        cfg_step = 1'b0;
        cfg_end  = 1'b0;
        idle     = 1'b0;
        cnv      = 1'b0;
        m_valid  = 1'b0;
`ifdef ADC_BUSY_TIMEOUT_EN
        to_set   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                idle = 1'b1;
                // configuration wins over a simultaneous start
                if (cfg_req) begin
                    state_n  = CFG_XFER;
                    go       = 1'b1;
                    tx_word  = CmdEnter;
                    pulses   = CfgPulses;
                    load_cfg = 1'b1;
                end else if (start) begin
                    state_n = CNV_PULSE;
                    cnt_clr = 1'b1;
                end
            end
            CNV_PULSE: begin
                cnv = 1'b1;
                if (cnt == 16'(CNV_HIGH - 1)) begin
                    state_n = WAIT_BUSY;
                    cnt_clr = 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (seen_high && !busy_s) begin
                    state_n = RD_XFER;
                    go      = 1'b1;
                end
`ifdef ADC_BUSY_TIMEOUT_EN
                else if (cnt == 16'(BUSY_TIMEOUT - 1)) begin
                    state_n = CSN_WAIT;
                    cnt_clr = 1'b1;
                    to_set  = 1'b1;
                end
`endif
            end
            RD_XFER: begin
                if (done) begin
                    state_n = OUT;
                    cap     = 1'b1;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_n = CSN_WAIT;
                    cnt_clr = 1'b1;
                end
            end
            CFG_XFER: begin
                if (done) begin
                    state_n = CSN_WAIT;
                    cnt_clr = 1'b1;
                end
            end
            CSN_WAIT: begin
                if (cnt == 16'(CSN_GAP - 1)) begin
                    if (!cfg_active) begin
                        state_n = IDLE;
                    end else if (cfg_idx == 2'd2) begin
                        state_n = IDLE;
                        cfg_end = 1'b1;
                    end else begin
                        state_n  = CFG_XFER;
                        go       = 1'b1;
                        pulses   = CfgPulses;
                        tx_word  = cfg_cmd(2'(cfg_idx + 2'd1), md_lat);
                        cfg_step = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // sdo[0] carries the most significant bit of each lane group
    always_comb begin
        sr_shift = {sr[30:0], sdo[0]};
        unique case (lane_md_r)
            LaneModeTwo:  sr_shift = {sr[29:0], sdo[0], sdo[1]};
            LaneModeFour: sr_shift = {sr[27:0], sdo[0], sdo[1], sdo[2], sdo[3]};
            default:      sr_shift = {sr[30:0], sdo[0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            busy_m     <= 1'b0;
            busy_s     <= 1'b0;
            seen_high  <= 1'b0;
            sr         <= '0;
            m_data_r   <= '0;
            lane_md_r  <= LaneModeOne;
            md_lat     <= LaneModeOne;
            cfg_idx    <= '0;
            cfg_active <= 1'b0;
        end else begin
            busy_m <= busy;
            busy_s <= busy_m;
            cnt    <= cnt_clr ? '0 : cnt + 16'd1;

            if (state == IDLE)
                seen_high <= 1'b0;
            else if (busy_s && (state == CNV_PULSE || state == WAIT_BUSY))
                seen_high <= 1'b1;

            if (go)
                sr <= '0;
            else if (sample && state == RD_XFER)
                sr <= sr_shift;

            if (cap) m_data_r <= sr;

            if (load_cfg) begin
                md_lat     <= (cfg_lane_md == 2'b11) ? LaneModeOne : cfg_lane_md;
                cfg_idx    <= '0;
                cfg_active <= 1'b1;
            end else if (cfg_step) begin
                cfg_idx <= cfg_idx + 2'd1;
            end

            if (cfg_end) begin
                lane_md_r  <= md_lat;
                cfg_active <= 1'b0;
            end
        end
    end

    assign m_data  = m_data_r;
    assign lane_md = lane_md_r;

`ifdef ADC_BUSY_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset)       timeout_r <= 1'b0;
        else if (to_set) timeout_r <= 1'b1;
    end
    assign timeout = timeout_r;
`else
    logic unused_busy_timeout;
    assign unused_busy_timeout = (BUSY_TIMEOUT != 0);
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: ADC device model plus scoreboard for readback samples,
// sck pulse counts and register-access command words.
`timescale 1ns/1ps
module tb_adc_capture_ctrl;

    localparam int SCK_DIV      = 2;
    localparam int CNV_HIGH     = 4;
    localparam int CSN_GAP      = 4;
    localparam int BUSY_TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cfg_req = 1'b0;
    logic [1:0]  cfg_lane_md = 2'b00;
    logic        idle;
    logic [1:0]  lane_md;
    logic        cnv;
    logic        busy = 1'b0;
    logic        sck;
    logic        csn;
    logic        sdi;
    logic [3:0]  sdo = 4'h0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        timeout;

    always #5 clk = ~clk;

    adc_capture_ctrl #(
        .SCK_DIV      (SCK_DIV),
        .CNV_HIGH     (CNV_HIGH),
        .CSN_GAP      (CSN_GAP),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_req     (cfg_req),
        .cfg_lane_md (cfg_lane_md),
        .idle        (idle),
        .lane_md     (lane_md),
        .cnv         (cnv),
        .busy        (busy),
        .sck         (sck),
        .csn         (csn),
        .sdi         (sdi),
        .sdo         (sdo),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .timeout     (timeout)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_data[$];
    logic [23:0] exp_cmd[$];
    int          exp_rises[$];

    // device model state
    logic [31:0] pattern = 32'h0;
    logic [31:0] mshift = 32'h0;
    logic [1:0]  model_md = 2'b00;
    logic [1:0]  pend_md = 2'b00;
    logic [23:0] cmd_sr = 24'h0;
    bit          reg_access = 1'b0;
    bit          xfer_open = 1'b0;
    bit          skip_xfer = 1'b0;
    bit          busy_hold = 1'b0;
    int          xfer_rises = 0;
    int          cnv_count = 0;
    int          csn_falls = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] lanes_of(input logic [31:0] s,
                                           input logic [1:0] md);
        case (md)
            2'b01:   return {2'b00, s[30], s[31]};
            2'b10:   return {s[28], s[29], s[30], s[31]};
            default: return {3'b000, s[31]};
        endcase
    endfunction

    function automatic int width_of(input logic [1:0] md);
        case (md)
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    always @(posedge cnv) begin
        cnv_count++;
        if (!busy_hold) begin
            #15 busy = 1'b1;
            #200 busy = 1'b0;
        end
    end

    always @(negedge csn) begin
        xfer_open  = 1'b1;
        xfer_rises = 0;
        cmd_sr     = 24'h0;
        mshift     = pattern;
        sdo        = lanes_of(mshift, model_md);
        csn_falls++;
    end

    always @(posedge sck) begin
        if (csn === 1'b0) begin
            xfer_rises++;
            cmd_sr = {cmd_sr[22:0], sdi};
            #8;
            mshift = mshift << width_of(model_md);
            sdo    = lanes_of(mshift, model_md);
        end
    end

    always @(posedge csn) begin
        if (xfer_open) begin
            xfer_open = 1'b0;
            if (skip_xfer) begin
                skip_xfer = 1'b0;
            end else if (xfer_rises == 24) begin
                if (exp_cmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sdi_cmd: got %h expected none", cmd_sr);
                end else begin
                    check("sdi_cmd", 32'(cmd_sr), 32'(exp_cmd.pop_front()));
                end
                if (cmd_sr == 24'hA00000) begin
                    reg_access = 1'b1;
                end else if (cmd_sr == 24'h001401) begin
                    if (reg_access) model_md = pend_md;
                    reg_access = 1'b0;
                end else if (reg_access && !cmd_sr[23] && cmd_sr[22:8] == 15'h0020) begin
                    pend_md = cmd_sr[7:6];
                end
            end else begin
                if (exp_rises.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sck_rises: got %0d expected none", xfer_rises);
                end else begin
                    check("sck_rises", 32'(xfer_rises), 32'(exp_rises.pop_front()));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m_data: got %h expected none", m_data);
            end else begin
                check("m_data", m_data, exp_data.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && idle !== 1'b1; i++) tick();
        check("idle_reached", 32'(idle), 32'd1);
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; i < limit && m_valid !== 1'b1; i++) tick();
        check("valid_seen", 32'(m_valid), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] pat, input int rises);
        pattern = pat;
        exp_data.push_back(pat);
        exp_rises.push_back(rises);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(3000);
        repeat (5) tick();
        check("m_valid_hold", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("m_valid_drop", 32'(m_valid), 32'd0);
        wait_idle(200);
    endtask

    task automatic do_cfg(input logic [1:0] md, input logic [23:0] mode_word,
                          input logic [1:0] exp_md);
        exp_cmd.push_back(24'hA00000);
        exp_cmd.push_back(mode_word);
        exp_cmd.push_back(24'h001401);
        cfg_lane_md = md;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        wait_idle(2000);
        check("lane_md", 32'(lane_md), 32'(exp_md));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) tick();
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_csn", 32'(csn), 32'd1);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_cnv", 32'(cnv), 32'd0);
        check("rst_sdi", 32'(sdi), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_lane_md", 32'(lane_md), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        tick();

        do_read(32'hDEADBEEF, 32);

        do_cfg(2'b10, 24'h002080, 2'b10);
        do_read(32'h12345678, 8);

        do_cfg(2'b01, 24'h002040, 2'b01);
        do_read(32'hA5A50F0F, 16);

        // simultaneous requests: configuration only, no conversion
        n = cnv_count;
        exp_cmd.push_back(24'hA00000);
        exp_cmd.push_back(24'h002080);
        exp_cmd.push_back(24'h001401);
        cfg_lane_md = 2'b10;
        cfg_req = 1'b1;
        start = 1'b1;
        tick();
        cfg_req = 1'b0;
        start = 1'b0;
        repeat (20) tick();
        check("busy_not_idle", 32'(idle), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(2000);
        check("no_cnv", 32'(cnv_count), 32'(n));
        check("lane_md_both", 32'(lane_md), 32'd2);

        // reserved mode 11 is coerced to one lane
        do_cfg(2'b11, 24'h002000, 2'b00);
        do_read(32'h0F1E2D3C, 32);

        // reset during a two-lane readback
        do_cfg(2'b01, 24'h002040, 2'b01);
        pattern = 32'hCAFEF00D;
        skip_xfer = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3000 && !(xfer_open && xfer_rises >= 10); i++) tick();
        check("reach_pulse10", 32'(xfer_rises), 32'd10);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_csn", 32'(csn), 32'd1);
        check("abort_idle", 32'(idle), 32'd1);
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_lane_md", 32'(lane_md), 32'd0);
        check("abort_sck", 32'(sck), 32'd0);
        model_md = 2'b00;
        reg_access = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        do_read(32'h89ABCDEF, 32);

`ifdef ADC_BUSY_TIMEOUT_EN
        busy_hold = 1'b1;
        busy = 1'b1;
        repeat (4) tick();
        n = csn_falls;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(BUSY_TIMEOUT + 200);
        check("timeout_set", 32'(timeout), 32'd1);
        check("timeout_no_csn", 32'(csn_falls), 32'(n));
        check("timeout_no_valid", 32'(m_valid), 32'd0);
        busy = 1'b0;
        busy_hold = 1'b0;
`else
        check("timeout_tied", 32'(timeout), 32'd0);
`endif

        repeat (10) tick();
        check("data_queue_empty", 32'(exp_data.size()), 32'd0);
        check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        check("rises_queue_empty", 32'(exp_rises.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
